// File: rtl/axi_stream_burst_writer.sv
// axi_stream_burst_writer: FIFO-buffered stream to AXI4 INCR burst writer; define STREAM_WRITER_BRESP_CHK_EN for o_err/o_err_cnt bresp tracking
module axi_stream_burst_writer #(
  parameter int          G_DATAWIDTH  = 32,
  parameter int          G_ID_WIDTH   = 1,
  parameter int          G_BURSTLEN   = 16,
  parameter int          G_FIFO_DEPTH = 32,
  parameter logic [31:0] G_BASEADDR   = 32'h0
) (
  input  logic                   s_aclk,
  input  logic                   s_areset,
  input  logic [G_DATAWIDTH-1:0] s_tdata,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic                   s_tlast,
  output logic [G_ID_WIDTH-1:0]  m_axi_awid,
  output logic [31:0]            m_axi_awaddr,
  output logic [7:0]             m_axi_awlen,
  output logic [2:0]             m_axi_awsize,
  output logic [1:0]             m_axi_awburst,
  output logic                   m_axi_awvalid,
  input  logic                   m_axi_awready,
  output logic [G_DATAWIDTH-1:0] m_axi_wdata,
  output logic [3:0]             m_axi_wstrb,
  output logic                   m_axi_wlast,
  output logic                   m_axi_wvalid,
  input  logic                   m_axi_wready,
  input  logic [G_ID_WIDTH-1:0]  m_axi_bid,
  input  logic [1:0]             m_axi_bresp,
  input  logic                   m_axi_bvalid,
  output logic                   m_axi_bready,
  output logic                   o_busy,
  output logic [31:0]            o_wr_addr,
  output logic [15:0]            o_burst_cnt
`ifdef STREAM_WRITER_BRESP_CHK_EN
  ,
  output logic                   o_err,
  output logic [7:0]             o_err_cnt
`endif
);
  localparam int AW = $clog2(G_FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
  state_t                 state_q;
  logic [G_DATAWIDTH-1:0] mem_q [G_FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]          count_q, count_d;
  logic                   flush_q, flush_d;
  logic [8:0]             len_q, rem_q, len_d;
  logic [31:0]            awaddr_q, wr_addr_q;
  logic [7:0]             awlen_q;
  logic [15:0]            burst_cnt_q;
  logic                   awvalid_q, wvalid_q, wlast_q, bready_q;
  logic                   push, pop, full_burst, launch, b_hs;
  logic                   unused_ok;
`ifdef STREAM_WRITER_BRESP_CHK_EN
  logic                   err_q;
  logic [7:0]             err_cnt_q;
  assign o_err     = err_q;
  assign o_err_cnt = err_cnt_q;
`endif
  assign unused_ok     = ^{m_axi_bid, m_axi_bresp};
  assign s_tready      = count_q != CW'(G_FIFO_DEPTH);
  assign push          = s_tvalid & s_tready;
  assign pop           = wvalid_q & m_axi_wready;
  assign b_hs          = bready_q & m_axi_bvalid;
  assign count_d       = count_q + CW'(push) - CW'(pop);
  assign full_burst    = count_q >= CW'(G_BURSTLEN);
  assign launch        = state_q == IDLE && (full_burst || (flush_q && count_q != '0));
  assign len_d         = full_burst ? 9'(G_BURSTLEN) : 9'(count_q);
  // a newly accepted tlast always wins over any clear in the same cycle
  assign flush_d       = (push & s_tlast) ? 1'b1 :
                         ((state_q == IDLE && count_q == '0) || (b_hs && count_d == '0)) ? 1'b0 : flush_q;
  assign m_axi_awid    = '0;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_awsize  = 3'b010;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = mem_q[rd_ptr_q];
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wlast   = wlast_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign o_busy        = state_q != IDLE || count_q != '0;
  assign o_wr_addr     = wr_addr_q;
  assign o_burst_cnt   = burst_cnt_q;

  always_ff @(posedge s_aclk)
    if (push) mem_q[wr_ptr_q] <= s_tdata;

  always_ff @(posedge s_aclk or posedge s_areset)
    if (s_areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      flush_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(push);
      rd_ptr_q <= rd_ptr_q + AW'(pop);
      count_q  <= count_d;
      flush_q  <= flush_d;
    end

  always_ff @(posedge s_aclk or posedge s_areset)
    if (s_areset) begin
      state_q     <= IDLE;
      awaddr_q    <= '0;
      awlen_q     <= '0;
      len_q       <= '0;
      rem_q       <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      wlast_q     <= 1'b0;
      bready_q    <= 1'b0;
      wr_addr_q   <= G_BASEADDR;
      burst_cnt_q <= '0;
`ifdef STREAM_WRITER_BRESP_CHK_EN
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (launch) begin
          awaddr_q  <= wr_addr_q;
          awlen_q   <= 8'(len_d - 9'd1);
          len_q     <= len_d;
          awvalid_q <= 1'b1;
          state_q   <= ADDR;
        end
        ADDR: if (m_axi_awready) begin
          awvalid_q <= 1'b0;
          wvalid_q  <= 1'b1;
          wlast_q   <= len_q == 9'd1;
          rem_q     <= len_q;
          state_q   <= DATA;
        end
        DATA: if (m_axi_wready) begin
          rem_q   <= rem_q - 9'd1;
          wlast_q <= rem_q == 9'd2;
          if (rem_q == 9'd1) begin
            wvalid_q <= 1'b0;
            wlast_q  <= 1'b0;
            bready_q <= 1'b1;
            state_q  <= RESP;
          end
        end
        RESP: if (m_axi_bvalid) begin
          bready_q    <= 1'b0;
          wr_addr_q   <= wr_addr_q + {21'b0, len_q, 2'b00};
          burst_cnt_q <= burst_cnt_q + 16'd1;
          state_q     <= IDLE;
`ifdef STREAM_WRITER_BRESP_CHK_EN
          if (m_axi_bresp != 2'b00) begin
            err_q <= 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
          end
`endif
        end
      endcase
    end
endmodule
